elevator_call_latch: RTL and testbench

- Upstream stage of the elevator ASM controller. Latches momentary floor-call button presses into held requests and drives the controller's ra/rb/rc/rd request inputs.
- Sequences the door open/close dwell when the car reaches a called floor. While the door is open or closing, it holds the car at its floor by asserting only that floor's request.
- Consumes the controller's floor and dir outputs.

---
 rtl/elevator_call_latch.sv | 125 ++++++++++++
 tb/tb_elevator_call_latch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/elevator_call_latch.sv
// elevator_call_latch: latches floor-call buttons into held requests and
// sequences the door open/close dwell when the car reaches a called floor.
module elevator_call_latch #(
   parameter int unsigned DWELL = 4,   // door-open duration in cycles (1..255)
   parameter int unsigned CLOSE = 2    // door-closing duration in cycles (1..255)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic [1:0] floor,
   input  logic       dir,
   output logic       ra,
   output logic       rb,
   output logic       rc,
   output logic       rd,
   output logic       door_open,
   output logic       busy
);

   localparam int unsigned TW = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_OPEN    = 2'd1;
   localparam logic [1:0] ST_CLOSING = 2'd2;

   localparam logic [TW-1:0] DWELL_M1 = TW'(DWELL - 1);
   localparam logic [TW-1:0] CLOSE_M1 = TW'(CLOSE - 1);

   logic [1:0]    r_state;
   logic [3:0]    r_pend;
   logic [TW-1:0] r_timer;

   logic [1:0]    w_state_nxt;
   logic [3:0]    w_pend_nxt;
   logic [TW-1:0] w_timer_nxt;

   logic [3:0]    w_req;
   logic [3:0]    w_floor_oh;
   logic          w_hit;
   logic [3:0]    w_req_out;

   // Direction is informational only; kept as a named sink.
   logic          w_dir_unused;
   assign w_dir_unused = dir;

   assign w_req      = r_pend | btn;
   assign w_floor_oh = 4'b0001 << floor;
   assign w_hit      = w_req[floor];

   // State, pending-call and timer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_pend  <= 4'b0000;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   // Next-state, call-latching and dwell-timer logic.
   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_timer_nxt = r_timer;
      case (r_state)
         ST_IDLE: begin
            if (w_hit) begin
               // Serve the current floor; other presses this cycle are kept.
               w_state_nxt = ST_OPEN;
               w_timer_nxt = DWELL_M1;
               w_pend_nxt  = w_req & ~w_floor_oh;
            end else begin
               w_pend_nxt  = w_req;
            end
         end
         ST_OPEN: begin
            w_pend_nxt = w_req & ~w_floor_oh;
            if (btn[floor]) begin
               w_timer_nxt = DWELL_M1;
            end else if (r_timer == '0) begin
               w_state_nxt = ST_CLOSING;
               w_timer_nxt = CLOSE_M1;
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         ST_CLOSING: begin
            w_pend_nxt = w_req & ~w_floor_oh;
            if (btn[floor]) begin
               w_state_nxt = ST_OPEN;
               w_timer_nxt = DWELL_M1;
            end else if (r_timer == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   // Request/door decode: pending calls in IDLE, hold at current floor otherwise.
   always_comb begin
      w_req_out = r_pend;
      door_open = 1'b0;
      busy      = 1'b0;
      if (r_state == ST_OPEN) begin
         w_req_out = w_floor_oh;
         door_open = 1'b1;
         busy      = 1'b1;
      end else if (r_state == ST_CLOSING) begin
         w_req_out = w_floor_oh;
         busy      = 1'b1;
      end
   end

   assign {rd, rc, rb, ra} = w_req_out;

endmodule

// File: tb/tb_elevator_call_latch.sv
// Directed self-checking bench for elevator_call_latch (DWELL=4, CLOSE=2).
module tb_elevator_call_latch;

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic [1:0] floor;
   logic       dir;
   logic       ra, rb, rc, rd, door_open, busy;

   int n_tests = 0;
   int n_fail  = 0;

   elevator_call_latch #(.DWELL(4), .CLOSE(2)) dut (
      .clk(clk), .rst(rst), .btn(btn), .floor(floor), .dir(dir),
      .ra(ra), .rb(rb), .rc(rc), .rd(rd),
      .door_open(door_open), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare {busy, door_open, rd, rc, rb, ra} against an expected value.
   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      #1;
      obs = {busy, door_open, rd, rc, rb, ra};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; btn = 4'b1111; floor = 2'd0; dir = 1'b0;

      // Reset held two edges with all buttons pressed.
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1; btn = 4'b0000;
      chk("reset", 6'b00_0000);

      // Remote call at floor C while car at A.
      btn = 4'b0100;
      tick();
      btn = 4'b0000;
      chk("remote_latch", 6'b00_0100);
      tick();
      chk("remote_held", 6'b00_0100);

      // Arrive at C: door opens, dwell 4 cycles then close 2 cycles.
      floor = 2'd2;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("dwell_open_%0d", i), 6'b11_0100);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dwell_close_%0d", i), 6'b10_0100);
         tick();
      end
      chk("dwell_idle", 6'b00_0000);

      // Reopen from CLOSING with a press at the current floor.
      btn = 4'b0100;
      tick();
      btn = 4'b0000;
      chk("reopen_first_open", 6'b11_0100);
      for (int i = 0; i < 4; i++) tick();
      chk("reopen_closing", 6'b10_0100);
      btn = 4'b0100;
      tick();
      btn = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reopen_open_%0d", i), 6'b11_0100);
         tick();
      end
      chk("reopen_close_0", 6'b10_0100);
      tick();
      chk("reopen_close_1", 6'b10_0100);
      tick();
      chk("reopen_idle_no_pend", 6'b00_0000);

      // Multiple calls during dwell at floor B.
      floor = 2'd1;
      btn   = 4'b0010;
      tick();
      btn = 4'b1001;
      tick();
      btn = 4'b0000;
      chk("multi_open_t2", 6'b11_0010);
      tick();
      chk("multi_open_t1", 6'b11_0010);
      tick();
      chk("multi_open_t0", 6'b11_0010);
      tick();
      chk("multi_close_0", 6'b10_0010);
      tick();
      chk("multi_close_1", 6'b10_0010);
      tick();
      chk("multi_idle_pend", 6'b00_1001);
      tick();
      chk("multi_idle_hold", 6'b00_1001);

      // Serve A leaving pend=1000, then reset on the 2nd OPEN cycle.
      floor = 2'd0;
      tick();
      chk("mid_open_1", 6'b11_0001);
      tick();
      chk("mid_open_2", 6'b11_0001);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_reset", 6'b00_0000);
      tick();
      chk("mid_reset_pend_clear", 6'b00_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
